// File: rtl/mc_datapath_if.sv
// Shared instruction/data memory port of mc_datapath: the datapath is the master,
// the memory system the slave. A request completes in the cycle mem_ack is high.
interface mc_datapath_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mc_datapath.sv
// Multi-cycle datapath (FETCH/DECODE/EXECUTE/MEM/WB) sharing one memory port for fetch and data.
// Optional performance counters cycle_cnt/instret_cnt are enabled by defining MC_DATAPATH_PERF_EN.
module mc_datapath #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter logic [XLEN-1:0] PC_INC   = {{(XLEN-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  mc_datapath_if.master    mem,
  input  logic [2:0]       op_kind,
  input  logic [3:0]       alu_ctrl,
  input  logic             alu_src,
  input  logic             br_inv,
  input  logic [XLEN-1:0]  imm_ext,
  output logic [XLEN-1:0]  instr,
  output logic [XLEN-1:0]  pc,
  output logic             zero,
  output logic             retire,
  output logic             illegal
`ifdef MC_DATAPATH_PERF_EN
  ,
  output logic [XLEN-1:0]  cycle_cnt,
  output logic [XLEN-1:0]  instret_cnt
`endif
);
  localparam int unsigned     RW     = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned     SW     = $clog2(XLEN);
  localparam logic [XLEN-1:0] ZERO_C = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONE_C  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0]   X0_C   = {RW{1'b0}};

  localparam logic [2:0] K_ALU_R  = 3'd0;
  localparam logic [2:0] K_ALU_I  = 3'd1;
  localparam logic [2:0] K_LOAD   = 3'd2;
  localparam logic [2:0] K_STORE  = 3'd3;
  localparam logic [2:0] K_BRANCH = 3'd4;
  localparam logic [2:0] K_JAL    = 3'd5;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4
  } state_e;

  state_e          state_r, next_s;
  logic [XLEN-1:0] pc_r, oldpc_r, ir_r, a_r, b_r, aluout_r, mdr_r;
  logic [XLEN-1:0] rf_r [NREGS];
  logic [2:0]      kind_r;
  logic            zero_r, mem_req_r, mem_we_r, retire_r, illegal_r;

  logic [RW-1:0]   rs1_s, rs2_s, rd_s;
  logic [XLEN-1:0] alu_b_s, alu_res_s, rd1_s, rd2_s;
  logic            ack_s, legal_s, taken_s;

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] ctrl,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [SW-1:0] sh;
    sh = b[SW-1:0];
    case (ctrl)
      4'd0:    alu_f = a + b;
      4'd1:    alu_f = a - b;
      4'd2:    alu_f = a & b;
      4'd3:    alu_f = a | b;
      4'd4:    alu_f = a ^ b;
      4'd5:    alu_f = ($signed(a) < $signed(b)) ? ONE_C : ZERO_C;
      4'd6:    alu_f = (a < b) ? ONE_C : ZERO_C;
      4'd7:    alu_f = a << sh;
      4'd8:    alu_f = a >> sh;
      4'd9:    alu_f = $unsigned($signed(a) >>> sh);
      default: alu_f = ZERO_C;
    endcase
  endfunction

  // Operand selection, register-file reads and branch/handshake qualifiers
  always_comb begin
    rs1_s     = ir_r[15 +: RW];
    rs2_s     = ir_r[20 +: RW];
    rd_s      = ir_r[7 +: RW];
    rd1_s     = (rs1_s == X0_C) ? ZERO_C : rf_r[rs1_s];
    rd2_s     = (rs2_s == X0_C) ? ZERO_C : rf_r[rs2_s];
    alu_b_s   = alu_src ? imm_ext : b_r;
    alu_res_s = alu_f(alu_ctrl, a_r, alu_b_s);
    taken_s   = (alu_res_s == ZERO_C) ^ br_inv;
    // An ack only counts while our own request is actually on the bus
    ack_s     = mem_req_r & mem.mem_ack;
    legal_s   = (op_kind <= K_JAL);
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      FETCH:   next_s = ack_s ? DECODE : FETCH;
      DECODE:  next_s = legal_s ? EXECUTE : FETCH;
      EXECUTE: begin
        case (kind_r)
          K_ALU_R, K_ALU_I, K_JAL: next_s = WB;
          K_LOAD, K_STORE:         next_s = MEM;
          default:                 next_s = FETCH;
        endcase
      end
      MEM:     next_s = ack_s ? ((kind_r == K_LOAD) ? WB : FETCH) : MEM;
      WB:      next_s = FETCH;
      default: next_s = FETCH;
    endcase
  end

  // Registered bus strobes and status pulses, decoded from the upcoming state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_r <= 1'b0;
      mem_we_r  <= 1'b0;
      retire_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      mem_req_r <= (next_s == FETCH) || (next_s == MEM);
      mem_we_r  <= (next_s == MEM) && (kind_r == K_STORE);
      retire_r  <= (next_s == FETCH) &&
                   ((state_r == EXECUTE) || (state_r == MEM) || (state_r == WB));
      illegal_r <= (state_r == DECODE) && !legal_s;
    end
  end

  // Architectural registers and register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r     <= RESET_PC;
      oldpc_r  <= ZERO_C;
      ir_r     <= ZERO_C;
      a_r      <= ZERO_C;
      b_r      <= ZERO_C;
      aluout_r <= ZERO_C;
      mdr_r    <= ZERO_C;
      zero_r   <= 1'b0;
      kind_r   <= K_ALU_R;
      rf_r     <= '{default: ZERO_C};
    end else begin
      case (state_r)
        FETCH: begin
          if (ack_s) begin
            ir_r    <= mem.mem_rdata;
            oldpc_r <= pc_r;
            pc_r    <= pc_r + PC_INC;
          end
        end
        DECODE: begin
          if (legal_s) begin
            a_r    <= rd1_s;
            b_r    <= rd2_s;
            kind_r <= op_kind;
          end
        end
        EXECUTE: begin
          zero_r   <= (alu_res_s == ZERO_C);
          aluout_r <= (kind_r == K_JAL) ? (oldpc_r + PC_INC) : alu_res_s;
          if ((kind_r == K_JAL) || ((kind_r == K_BRANCH) && taken_s)) begin
            pc_r <= oldpc_r + imm_ext;
          end
        end
        MEM: begin
          if (ack_s && (kind_r == K_LOAD)) begin
            mdr_r <= mem.mem_rdata;
          end
        end
        WB: begin
          if (rd_s != X0_C) begin
            rf_r[rd_s] <= (kind_r == K_LOAD) ? mdr_r : aluout_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MC_DATAPATH_PERF_EN
  logic [XLEN-1:0] cycle_cnt_r, instret_cnt_r;

  // Free-running cycle counter and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_r   <= ZERO_C;
      instret_cnt_r <= ZERO_C;
    end else begin
      cycle_cnt_r   <= cycle_cnt_r + ONE_C;
      instret_cnt_r <= retire_r ? (instret_cnt_r + ONE_C) : instret_cnt_r;
    end
  end

  assign cycle_cnt   = cycle_cnt_r;
  assign instret_cnt = instret_cnt_r;
`endif

  // Data address is only presented in MEM; every other state exposes the PC
  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = (state_r == MEM) ? aluout_r : pc_r;
  assign mem.mem_wdata = b_r;
  assign instr         = ir_r;
  assign pc            = pc_r;
  assign zero          = zero_r;
  assign retire        = retire_r;
  assign illegal       = illegal_r;
endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: a table-driven decoder and a latency-programmable memory
// model; expected retire results are queued per program and compared on each retire pulse.
module tb_mc_datapath;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  op_kind;
  logic [3:0]  alu_ctrl;
  logic        alu_src, br_inv;
  logic [31:0] imm_ext, instr, pc;
  logic        zero, retire, illegal;
`ifdef MC_DATAPATH_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  mc_datapath_if #(.XLEN(32)) mif ();

  mc_datapath dut (
    .clk(clk), .reset(reset), .mem(mif),
    .op_kind(op_kind), .alu_ctrl(alu_ctrl), .alu_src(alu_src), .br_inv(br_inv),
    .imm_ext(imm_ext), .instr(instr), .pc(pc), .zero(zero), .retire(retire),
    .illegal(illegal)
`ifdef MC_DATAPATH_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  // Bench decoder: kind[2:0] ctrl[6:3] rd[11:7] src[12] inv[13] rs1[19:15] rs2[24:20] imm[31:25]
  assign op_kind  = instr[2:0];
  assign alu_ctrl = instr[6:3];
  assign alu_src  = instr[12];
  assign br_inv   = instr[13];
  assign imm_ext  = {{25{instr[31]}}, instr[31:25]};

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          rd;
    logic [31:0] val;
    logic        z;
    int          gap;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_arr [64];
  int          lat = 0;
  int          n_total = 0;
  int          n_bad = 0;
  int          n_illegal = 0;
  logic        st_seen = 1'b0;
  logic [31:0] st_data = 32'd0, st_addr = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] k, input logic [3:0] c, input logic s,
                                      input logic inv, input int rd, input int rs1,
                                      input int rs2, input int imm);
    logic [4:0] rdv, r1v, r2v;
    logic [6:0] iv;
    rdv = rd[4:0];
    r1v = rs1[4:0];
    r2v = rs2[4:0];
    iv  = imm[6:0];
    return {iv, r2v, r1v, 1'b0, inv, s, rdv, c, k};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc(3'd1, 4'd0, 1'b1, 1'b0, rd, rs1, 0, imm);
  endfunction

  function automatic logic [31:0] alur(input logic [3:0] c, input int rd, input int rs1,
                                       input int rs2);
    return enc(3'd0, c, 1'b0, 1'b0, rd, rs1, rs2, 0);
  endfunction

  function automatic logic [31:0] rf_read(input int i);
    return dut.rf_r[i];
  endfunction

  function automatic logic [31:0] rf_or();
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) r = r | dut.rf_r[i];
    return r;
  endfunction

  task automatic push(input logic [31:0] p, input int rd, input logic [31:0] v, input logic z,
                      input int gap);
    exp_t e;
    e.pc = p; e.rd = rd; e.val = v; e.z = z; e.gap = gap;
    sb_q.push_back(e);
  endtask

  // Memory model: acks after lat wait cycles, returns the addressed word, commits stores
  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'd0;
    forever begin
      int wait_cnt;
      wait_cnt = 0;
      forever begin
        @(negedge clk);
        if (mif.mem_req === 1'b1) begin
          if (wait_cnt >= lat) begin
            mif.mem_ack   = 1'b1;
            mif.mem_rdata = mem_arr[mif.mem_addr[5:0]];
            if (mif.mem_we === 1'b1) mem_arr[mif.mem_addr[5:0]] = mif.mem_wdata;
            wait_cnt = 0;
          end else begin
            mif.mem_ack = 1'b0;
            wait_cnt++;
          end
        end else begin
          mif.mem_ack = 1'b0;
          wait_cnt = 0;
        end
      end
    end
  end

  task automatic reset_and_start(input int lat_v);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req", {31'd0, mif.mem_req}, 32'd0);
    check_eq("rst_retire", {31'd0, retire}, 32'd0);
    check_eq("rst_pc", pc, 32'd0);
    check_eq("rst_ir", instr, 32'd0);
    check_eq("rst_rf", rf_or(), 32'd0);
    lat = lat_v;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4 && mif.mem_req !== 1'b1; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("start_req", {31'd0, mif.mem_req}, 32'd1);
    check_eq("start_addr", mif.mem_addr, 32'd0);
  endtask

  task automatic run_sb(input int budget);
    int          cyc, last, hold_err;
    logic        p_req, p_ack, p_we;
    logic [31:0] p_addr;
    exp_t        e;
    cyc = 0; last = -1; hold_err = 0;
    p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = 32'd0;
    while (sb_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
      // A pending request must keep req, address and direction until acked
      if (p_req && !p_ack &&
          (mif.mem_req !== 1'b1 || mif.mem_addr !== p_addr || mif.mem_we !== p_we)) hold_err++;
      p_req = mif.mem_req; p_ack = mif.mem_ack; p_we = mif.mem_we; p_addr = mif.mem_addr;
      if (illegal === 1'b1) n_illegal++;
      if (mif.mem_req === 1'b1 && mif.mem_we === 1'b1) begin
        st_seen = 1'b1;
        st_data = mif.mem_wdata;
        st_addr = mif.mem_addr;
      end
      if (retire === 1'b1) begin
        e = sb_q.pop_front();
        check_eq("pc", pc, e.pc);
        check_eq("rf", rf_read(e.rd), e.val);
        check_eq("zero", {31'd0, zero}, {31'd0, e.z});
        if (e.gap > 0) check_eq("retire_gap", cyc - last, e.gap);
        last = cyc;
      end
    end
    check_eq("sb_drain", sb_q.size(), 32'd0);
    check_eq("req_hold", hold_err, 32'd0);
    sb_q.delete();
  endtask

  initial begin
    bit found;
    // Program 1: ADDI, ADD, ADDI to x0, BEQ back to 0 (single-cycle memory)
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'd0;
    mem_arr[0] = addi(1, 0, 5);
    mem_arr[1] = alur(4'd0, 2, 1, 1);
    mem_arr[2] = addi(0, 0, 7);
    mem_arr[3] = enc(3'd4, 4'd1, 1'b0, 1'b0, 0, 1, 1, -3);
    reset_and_start(0);
    push(32'd1, 1, 32'd5, 1'b0, 0);
    push(32'd2, 2, 32'd10, 1'b0, 4);
    push(32'd3, 0, 32'd0, 1'b0, 4);
    push(32'd0, 1, 32'd5, 1'b1, 3);
    push(32'd1, 1, 32'd5, 1'b0, 4);
    run_sb(200);
`ifdef MC_DATAPATH_PERF_EN
    @(negedge clk);
    #1;
    check_eq("instret", instret_cnt, 32'd5);
`endif

    // Program 2: store then load through address 8 with two wait cycles per access
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'd0;
    mem_arr[0] = addi(2, 0, 10);
    mem_arr[1] = enc(3'd3, 4'd0, 1'b1, 1'b0, 0, 0, 2, 8);
    mem_arr[2] = enc(3'd2, 4'd0, 1'b1, 1'b0, 3, 0, 0, 8);
    reset_and_start(2);
    st_seen = 1'b0;
    push(32'd1, 2, 32'd10, 1'b0, 0);
    push(32'd2, 2, 32'd10, 1'b0, 8);
    push(32'd3, 3, 32'd10, 1'b0, 9);
    run_sb(300);
    check_eq("st_seen", {31'd0, st_seen}, 32'd1);
    check_eq("st_wdata", st_data, 32'd10);
    check_eq("st_addr", st_addr, 32'd8);

    // Program 3: BNE not taken, JAL, write to x0, illegal op, assorted ALU ops
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'd0;
    mem_arr[0]  = addi(1, 0, 5);
    mem_arr[1]  = addi(2, 0, 3);
    mem_arr[2]  = addi(4, 0, 1);
    mem_arr[3]  = enc(3'd4, 4'd1, 1'b0, 1'b1, 0, 1, 1, -3);
    mem_arr[4]  = addi(5, 0, 2);
    mem_arr[5]  = addi(6, 0, -1);
    mem_arr[6]  = addi(7, 0, 7);
    mem_arr[7]  = enc(3'd5, 4'd0, 1'b1, 1'b0, 1, 0, 0, 4);
    mem_arr[11] = addi(0, 0, 9);
    mem_arr[12] = enc(3'd7, 4'd0, 1'b0, 1'b0, 0, 0, 0, 0);
    mem_arr[13] = alur(4'd5, 8, 6, 1);
    mem_arr[14] = alur(4'd6, 9, 6, 1);
    mem_arr[15] = alur(4'd9, 10, 6, 2);
    mem_arr[16] = alur(4'd1, 11, 1, 5);
    mem_arr[17] = enc(3'd2, 4'd0, 1'b1, 1'b0, 12, 0, 0, 20);
    mem_arr[20] = 32'd77;
    reset_and_start(0);
    n_illegal = 0;
    push(32'd1, 1, 32'd5, 1'b0, 0);
    push(32'd2, 2, 32'd3, 1'b0, 4);
    push(32'd3, 4, 32'd1, 1'b0, 4);
    push(32'd4, 1, 32'd5, 1'b1, 3);
    push(32'd5, 5, 32'd2, 1'b0, 4);
    push(32'd6, 6, 32'hFFFF_FFFF, 1'b0, 4);
    push(32'd7, 7, 32'd7, 1'b0, 4);
    push(32'd11, 1, 32'd8, 1'b0, 4);
    push(32'd12, 0, 32'd0, 1'b0, 4);
    push(32'd14, 8, 32'd1, 1'b0, 6);
    push(32'd15, 9, 32'd0, 1'b1, 4);
    push(32'd16, 10, 32'hFFFF_FFFF, 1'b0, 4);
    push(32'd17, 11, 32'd6, 1'b0, 4);
    run_sb(400);
    check_eq("illegal_cnt", n_illegal, 32'd1);

    // The load at pc 17 now waits in MEM; pull reset while it is pending
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      if (mif.mem_req === 1'b1 && mif.mem_addr === 32'd20) found = 1'b1;
    end
    check_eq("mem_phase", {31'd0, found}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_req", {31'd0, mif.mem_req}, 32'd0);
    check_eq("abort_pc", pc, 32'd0);
    check_eq("abort_rf", rf_or(), 32'd0);
    reset_and_start(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
- Multi-cycle successor to the single-cycle datapath: one shared memory port for both instruction fetch and data access.
- Internal architectural registers: IR, OldPC, A, B, ALUOut, MDR.
- Internal sequencing FSM.
- External decoder supplies per-instruction control (op kind, ALU op, ALU source, extended immediate) from the IR contents exported by this block.
- Parametrised in data width, register count, reset PC and PC increment.

Parameters:
- XLEN, 32, datapath/register/address width.
- NREGS, 32, register-file entries (power of 2, 2..32); index = low clog2(NREGS) bits of IR rs1 [19:15], rs2 [24:20], rd [11:7].
- RESET_PC, 0, PC value on reset.
- PC_INC, 1, PC step per instruction (word-addressed default; 4 for byte addressing).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- op_kind  in  3  0=ALU_R 1=ALU_I 2=LOAD 3=STORE 4=BRANCH 5=JAL, others illegal; sampled in DECODE
- alu_ctrl  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA; others give 0
- alu_src  in  1  0: ALU B operand = B reg, 1: imm_ext
- br_inv  in  1  branch taken on Zero==0 instead of Zero==1
- imm_ext  in  XLEN  sign-extended immediate decoded from instr
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, valid with mem_req
- mem_addr  out  XLEN  request address
- mem_wdata  out  XLEN  store data
- mem_rdata  in  XLEN  read data, valid with mem_ack
- mem_ack  in  1  request completes this cycle
- instr  out  XLEN  IR contents
- pc  out  XLEN  current PC register
- zero  out  1  registered Zero of last EXECUTE
- retire  out  1  one-cycle pulse on instruction completion
- illegal  out  1  one-cycle pulse on illegal op_kind

Behaviour:
- Reset values: pc=RESET_PC; IR, OldPC, A, B, ALUOut, MDR, zero = 0; all register-file entries = 0; state=FETCH; mem_req, mem_we, retire, illegal = 0.
- Reset is asynchronous: asserting it mid-request drops mem_req in the same cycle, and the transaction is abandoned.
- States: FETCH, DECODE, EXECUTE, MEM, WB.
- FETCH
  - mem_req=1, mem_we=0, mem_addr=pc; held stable until mem_ack.
  - On ack: IR<=mem_rdata, OldPC<=pc, pc<=pc+PC_INC (mod 2^XLEN) -> DECODE.
  - Minimum fetch is 1 cycle (ack in the same cycle as req).
- DECODE
  - A<=RF[rs1], B<=RF[rs2]; x0 always reads 0.
  - Illegal op_kind: illegal pulses next cycle -> FETCH; no state change, no retire.
- EXECUTE
  - ALU computes A op (alu_src ? imm_ext : B); ALUOut<=result; zero<=(result==0).
  - Shifts use the low clog2(XLEN) bits of the operand.
  - SLT is signed; SLTU is unsigned.
  - ALU_R / ALU_I -> WB.
  - LOAD / STORE -> MEM.
  - BRANCH: taken when (result==0) xor br_inv; if taken, pc<=OldPC+imm_ext. Then -> FETCH with retire.
  - JAL: pc<=OldPC+imm_ext, ALUOut<=OldPC+PC_INC -> WB.
- MEM
  - mem_req=1, mem_addr=ALUOut, mem_we=(STORE), mem_wdata=B; held until mem_ack.
  - LOAD: MDR<=mem_rdata -> WB.
  - STORE: -> FETCH with retire.
- WB
  - RF[rd]<=(LOAD ? MDR : ALUOut); writes to rd==0 are discarded. -> FETCH with retire.
- mem_ack while mem_req=0 is ignored.
- mem_req is never dropped before ack.
- CPI: ALU=4, LOAD=5, STORE=4, BRANCH=3, JAL=4 cycles with 1-cycle ack; each extra wait cycle adds 1.
- PC arithmetic wraps modulo 2^XLEN.

Optional Feature:
- Macro MC_DATAPATH_PERF_EN.
- When defined, adds outputs cycle_cnt and instret_cnt (both XLEN).
  - cycle_cnt increments every cycle after reset.
  - instret_cnt increments on each retire pulse.
  - Both wrap and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: reset low for 3 cycles, release -> mem_req=1, mem_addr=0, retire=0, all registers read 0.
- ADDI x1,x0,5 (ALU_I, imm_ext=5, alu_ctrl=ADD) then ADD x2,x1,x1 -> x2=10, pc=2, two retire pulses 4 cycles apart.
- STORE x2 to addr 8 then LOAD x3 from 8, with mem_ack delayed 2 cycles -> mem_we=1, mem_wdata=10; x3=10; mem_req held until ack.
- BEQ x1,x1 at pc=3 with imm_ext=-3 -> pc=0 after 3 cycles.
- br_inv=1 with the same operands -> not taken, pc=4.
- JAL x1 at pc=7, imm_ext=4 -> pc=11, x1=8; ADDI to x0 -> x0 still reads 0.
- op_kind=7 -> illegal pulses once, no retire, registers unchanged; reset asserted mid-MEM -> mem_req=0 immediately, pc=RESET_PC.
